nrs_ls_estimator: RTL and testbench

- Downstream consumer of the NRS generator. Reads the per-subframe NRS QPSK bits through rd_addr_est and pairs each with the received NRS resource element streamed in from the demapper.
- Emits one least-squares channel estimate per RE. Pulses est_ack after all 16 REs (2 ports x 8 REs) so the generator can prepare the next subframe.

---
 rtl/nrs_pkg.sv | 20 ++
 rtl/nrs_conj_mult.sv | 46 ++++
 rtl/nrs_ls_estimator.sv | 169 ++++++++++++++++
 tb/tb_nrs_ls_estimator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : nrs_pkg                                                     |
// | Brief  : Shared defaults and FSM encoding for the NRS estimator.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package nrs_pkg;

    localparam int c_WIDTH_RE = 16;
    localparam int c_LINES    = 4;
    localparam int c_N_NRS    = 16;

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_FETCH   = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_RE = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_ACK     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/nrs_conj_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : nrs_conj_mult                                               |
// | Brief  : y * conj(x) for a QPSK x in {+/-1 +/- j}, halved (>>>1).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module nrs_conj_mult
    import nrs_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_RE
) (
    input  logic signed [WIDTH-1:0] i_y_r,
    input  logic signed [WIDTH-1:0] i_y_i,
    input  logic                    i_neg_a,
    input  logic                    i_neg_b,
    output logic signed [WIDTH-1:0] o_z_r,
    output logic signed [WIDTH-1:0] o_z_i
);

    logic signed [WIDTH:0] w_yr_ext;
    logic signed [WIDTH:0] w_yi_ext;
    logic signed [WIDTH:0] w_yr_a;
    logic signed [WIDTH:0] w_yi_a;
    logic signed [WIDTH:0] w_yr_b;
    logic signed [WIDTH:0] w_yi_b;
    logic signed [WIDTH:0] w_sum_r;
    logic signed [WIDTH:0] w_sum_i;

    assign w_yr_ext = {i_y_r[WIDTH-1], i_y_r};
    assign w_yi_ext = {i_y_i[WIDTH-1], i_y_i};

    // a and b are +/-1, so each product is a conditional negation
    assign w_yr_a = i_neg_a ? -w_yr_ext : w_yr_ext;
    assign w_yi_a = i_neg_a ? -w_yi_ext : w_yi_ext;
    assign w_yr_b = i_neg_b ? -w_yr_ext : w_yr_ext;
    assign w_yi_b = i_neg_b ? -w_yi_ext : w_yi_ext;

    assign w_sum_r = w_yr_a + w_yi_b;
    assign w_sum_i = w_yi_a - w_yr_b;

    // dropping bit 0 of the extended sum is an arithmetic shift (floor)
    assign o_z_r = w_sum_r[WIDTH:1];
    assign o_z_i = w_sum_i[WIDTH:1];

endmodule
`default_nettype wire

// File: rtl/nrs_ls_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : nrs_ls_estimator                                            |
// | Brief  : Per-RE least-squares channel estimate against the NRS set.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module nrs_ls_estimator
    import nrs_pkg::*;
#(
    parameter int WIDTH_RE = c_WIDTH_RE,
    parameter int LINES    = c_LINES,
    parameter int N_NRS    = c_N_NRS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       NRS_gen_ready,
    output logic [LINES-1:0]           rd_addr_est,
    input  logic                       nrs_est_r,
    input  logic                       nrs_est_i,
    input  logic                       re_valid,
    output logic                       re_ready,
    input  logic signed [WIDTH_RE-1:0] re_r,
    input  logic signed [WIDTH_RE-1:0] re_i,
    output logic                       est_valid,
    output logic signed [WIDTH_RE-1:0] est_r,
    output logic signed [WIDTH_RE-1:0] est_i,
    output logic [LINES-1:0]           est_index,
    output logic                       est_ack,
    output logic                       busy
);

    logic [c_ST_W-1:0]          r_state;
    logic [c_ST_W-1:0]          w_state_nxt;
    logic                       r_armed;
    logic [LINES-1:0]           r_k;
    logic                       r_first;
    logic                       r_c_r;
    logic                       r_c_i;
    logic                       r_est_valid;
    logic signed [WIDTH_RE-1:0] r_est_r;
    logic signed [WIDTH_RE-1:0] r_est_i;
    logic [LINES-1:0]           r_est_index;
    logic                       r_est_ack;

    logic                       w_re_ready;
    logic                       w_busy;
    logic                       w_in_ack;
    logic                       w_accept;
    logic                       w_abort;
    logic                       w_last;
    logic                       w_c_r;
    logic                       w_c_i;
    logic signed [WIDTH_RE-1:0] w_z_r;
    logic signed [WIDTH_RE-1:0] w_z_i;

    assign w_last   = (r_k == LINES'(N_NRS - 1));
    assign w_accept = re_valid & w_re_ready;
    assign w_abort  = ((r_state == c_ST_FETCH) || (r_state == c_ST_WAIT_RE)) && !NRS_gen_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_armed && NRS_gen_ready) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_nxt = NRS_gen_ready ? c_ST_WAIT_RE : c_ST_IDLE;
            end
            c_ST_WAIT_RE: begin
                if (!NRS_gen_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (re_valid) begin
                    w_state_nxt = w_last ? c_ST_ACK : c_ST_FETCH;
                end
            end
            c_ST_ACK: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_re_ready = 1'b0;
        w_busy     = 1'b1;
        w_in_ack   = 1'b0;
        case (r_state)
            c_ST_IDLE:    w_busy     = 1'b0;
            c_ST_WAIT_RE: w_re_ready = NRS_gen_ready;
            c_ST_ACK:     w_in_ack   = 1'b1;
            default:      w_busy     = 1'b1;
        endcase
    end

    // Registered NRS read lands in the first WAIT_RE cycle; use it directly there
    assign w_c_r = r_first ? nrs_est_r : r_c_r;
    assign w_c_i = r_first ? nrs_est_i : r_c_i;

    nrs_conj_mult #(
        .WIDTH (WIDTH_RE)
    ) u_conj_mult (
        .i_y_r   (re_r),
        .i_y_i   (re_i),
        .i_neg_a (w_c_r),
        .i_neg_b (w_c_i),
        .o_z_r   (w_z_r),
        .o_z_i   (w_z_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed     <= 1'b1;
            r_k         <= '0;
            r_first     <= 1'b0;
            r_c_r       <= 1'b0;
            r_c_i       <= 1'b0;
            r_est_valid <= 1'b0;
            r_est_r     <= '0;
            r_est_i     <= '0;
            r_est_index <= '0;
            r_est_ack   <= 1'b0;
        end else begin
            r_est_valid <= w_accept;
            r_est_ack   <= w_in_ack;
            r_first     <= (r_state == c_ST_FETCH);
            if (r_first) begin
                r_c_r <= nrs_est_r;
                r_c_i <= nrs_est_i;
            end
            if (w_in_ack) begin
                r_armed <= 1'b0;
            end else if (!NRS_gen_ready) begin
                r_armed <= 1'b1;
            end
            // k wraps to zero after the last RE, ready for the next subframe
            if (w_accept) begin
                r_est_r     <= w_z_r;
                r_est_i     <= w_z_i;
                r_est_index <= r_k;
                r_k         <= r_k + 1'b1;
            end else if ((r_state == c_ST_IDLE) || w_abort) begin
                r_k <= '0;
            end
        end
    end

    assign rd_addr_est = r_k;
    assign re_ready    = w_re_ready;
    assign busy        = w_busy;
    assign est_valid   = r_est_valid;
    assign est_r       = r_est_r;
    assign est_i       = r_est_i;
    assign est_index   = r_est_index;
    assign est_ack     = r_est_ack;

endmodule
`default_nettype wire

// File: tb/tb_nrs_ls_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_nrs_ls_estimator                                         |
// | Brief  : Scoreboard bench for nrs_ls_estimator.                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_nrs_ls_estimator;

    localparam int c_W = 16;
    localparam int c_L = 4;
    localparam int c_N = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  NRS_gen_ready = 1'b0;
    logic [c_L-1:0]        rd_addr_est;
    logic                  nrs_est_r = 1'b0;
    logic                  nrs_est_i = 1'b0;
    logic                  re_valid = 1'b0;
    logic                  re_ready;
    logic signed [c_W-1:0] re_r = '0;
    logic signed [c_W-1:0] re_i = '0;
    logic                  est_valid;
    logic signed [c_W-1:0] est_r;
    logic signed [c_W-1:0] est_i;
    logic [c_L-1:0]        est_index;
    logic                  est_ack;
    logic                  busy;

    nrs_ls_estimator #(
        .WIDTH_RE (c_W),
        .LINES    (c_L),
        .N_NRS    (c_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .NRS_gen_ready (NRS_gen_ready),
        .rd_addr_est   (rd_addr_est),
        .nrs_est_r     (nrs_est_r),
        .nrs_est_i     (nrs_est_i),
        .re_valid      (re_valid),
        .re_ready      (re_ready),
        .re_r          (re_r),
        .re_i          (re_i),
        .est_valid     (est_valid),
        .est_r         (est_r),
        .est_i         (est_i),
        .est_index     (est_index),
        .est_ack       (est_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [c_N-1:0] mem_r = '0;
    logic [c_N-1:0] mem_i = '0;
    int stim_r [c_N];
    int stim_i [c_N];
    int sb_idx[$];
    int sb_r[$];
    int sb_i[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_est = 0;
    int n_ack = 0;
    int last_est_cyc = -100;
    int tb_k = 0;
    int est0;
    int ack0;

    // generator-side NRS register with one-cycle read latency
    always @(posedge clk) begin
        nrs_est_r <= mem_r[rd_addr_est];
        nrs_est_i <= mem_i[rd_addr_est];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic void model(input logic cr, input logic ci, input int yr, input int yi,
                                  output int er, output int ei);
        int a;
        int b;
        a  = cr ? -1 : 1;
        b  = ci ? -1 : 1;
        er = (yr * a + yi * b) >>> 1;
        ei = (yi * a - yr * b) >>> 1;
    endfunction

    always @(negedge clk) begin
        int er;
        int ei;
        int xi;
        cyc++;
        if (!rst) begin
            if (est_valid) begin
                n_est++;
                if (sb_idx.size() == 0) begin
                    check("est_unexpected", 32'd1, 32'd0);
                end else begin
                    xi = sb_idx.pop_front();
                    er = sb_r.pop_front();
                    ei = sb_i.pop_front();
                    check("est_index", 32'(est_index), xi);
                    check("est_r", 32'(est_r), er);
                    check("est_i", 32'(est_i), ei);
                    if (xi == c_N - 1) last_est_cyc = cyc;
                end
            end
            if (est_ack) begin
                n_ack++;
                check("ack_timing", cyc - last_est_cyc, 32'd1);
            end
            if (re_valid && re_ready) begin
                model(mem_r[tb_k], mem_i[tb_k], int'(re_r), int'(re_i), er, ei);
                sb_idx.push_back(tb_k);
                sb_r.push_back(er);
                sb_i.push_back(ei);
                tb_k = (tb_k + 1) % c_N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_re(input int yr, input int yi);
        bit done;
        done     = 1'b0;
        re_r     = 16'(yr);
        re_i     = 16'(yi);
        re_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (re_ready) done = 1'b1;
            tick();
        end
        re_valid = 1'b0;
        if (!done) check("re_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_range(input int k0, input int k1);
        for (int k = k0; k < k1; k++) send_re(stim_r[k], stim_i[k]);
    endtask

    task automatic rearm();
        tick();
        NRS_gen_ready = 1'b0;
        tick();
        NRS_gen_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_rd_addr"}, 32'(rd_addr_est), 32'd0);
        check({tag, "_re_ready"}, 32'(re_ready), 32'd0);
        check({tag, "_est_valid"}, 32'(est_valid), 32'd0);
        check({tag, "_est_r"}, 32'(est_r), 32'd0);
        check({tag, "_est_i"}, 32'(est_i), 32'd0);
        check({tag, "_est_index"}, 32'(est_index), 32'd0);
        check({tag, "_est_ack"}, 32'(est_ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic randomize_stim();
        for (int k = 0; k < c_N; k++) begin
            stim_r[k] = int'($urandom_range(60000)) - 30000;
            stim_i[k] = int'($urandom_range(60000)) - 30000;
            mem_r[k]  = 1'($urandom);
            mem_i[k]  = 1'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // basic run: all bits zero, constant RE
        for (int k = 0; k < c_N; k++) begin
            stim_r[k] = 1000;
            stim_i[k] = 200;
        end
        mem_r = '0;
        mem_i = '0;
        est0 = n_est;
        ack0 = n_ack;
        tb_k = 0;
        NRS_gen_ready = 1'b1;
        send_range(0, c_N);
        repeat (3) tick();
        check("basic_count", n_est - est0, 32'd16);
        check("basic_ack", n_ack - ack0, 32'd1);
        check("basic_hold_r", 32'(est_r), 32'(600));
        check("basic_hold_i", 32'(est_i), -32'sd400);
        check("basic_hold_idx", 32'(est_index), 32'd15);

        // ready held high after ack must not start another run
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("no_rerun_busy", 32'(busy), 32'd0);
        end

        // sign mapping, extremes and backpressure at k=3
        randomize_stim();
        mem_r[0] = 1'b1; mem_i[0] = 1'b0; stim_r[0] = 1000;   stim_i[0] = 200;
        mem_r[1] = 1'b1; mem_i[1] = 1'b1; stim_r[1] = 1000;   stim_i[1] = 200;
        mem_r[2] = 1'b0; mem_i[2] = 1'b0; stim_r[2] = -32768; stim_i[2] = -32768;
        mem_r[3] = 1'b0; mem_i[3] = 1'b1; stim_r[3] = 32767;  stim_i[3] = -32768;
        est0 = n_est;
        ack0 = n_ack;
        tb_k = 0;
        rearm();
        send_range(0, 3);
        tick();
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_re_ready", 32'(re_ready), 32'd1);
            check("bp_no_est", 32'(est_valid), 32'd0);
        end
        tick();
        send_range(3, c_N);
        repeat (3) tick();
        check("bp_count", n_est - est0, 32'd16);
        check("bp_ack", n_ack - ack0, 32'd1);

        // abort at k=7 with an RE waiting
        randomize_stim();
        est0 = n_est;
        ack0 = n_ack;
        tb_k = 0;
        rearm();
        send_range(0, 7);
        tick();
        re_r = 16'(stim_r[7]);
        re_i = 16'(stim_i[7]);
        re_valid = 1'b1;
        NRS_gen_ready = 1'b0;
        @(negedge clk);
        check("abort_re_ready", 32'(re_ready), 32'd0);
        tick();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_est", 32'(est_valid), 32'd0);
        re_valid = 1'b0;
        repeat (3) tick();
        check("abort_count", n_est - est0, 32'd7);
        check("abort_no_ack", n_ack - ack0, 32'd0);

        // restart after abort begins again at index 0
        est0 = n_est;
        ack0 = n_ack;
        tb_k = 0;
        NRS_gen_ready = 1'b1;
        send_range(0, c_N);
        repeat (3) tick();
        check("restart_count", n_est - est0, 32'd16);
        check("restart_ack", n_ack - ack0, 32'd1);

        // reset mid-run at k=9
        randomize_stim();
        ack0 = n_ack;
        tb_k = 0;
        rearm();
        send_range(0, 9);
        tick();
        re_valid = 1'b1;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        re_valid = 1'b0;
        NRS_gen_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_ack", n_ack - ack0, 32'd0);
        check("sb_empty", 32'(sb_idx.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
